// File: rtl/useq_pkg.sv
// useq_pkg: microinstruction format, seq/mem encodings and fixed addresses for micro_sequencer
package useq_pkg;
    localparam int MI_W      = 40;
    localparam int CWRD_LSB  = 11;
    localparam int CWRD_BITS = 29;
    localparam int ADDR_BITS = 6;
    typedef enum logic [2:0] {
        SEQ_JUMP, SEQ_NEXT, SEQ_DISPATCH, SEQ_BRZ, SEQ_BRNZ, SEQ_CALL, SEQ_RET, SEQ_HALT
    } seq_e;
    typedef enum logic [1:0] {MEM_NONE, MEM_RD, MEM_WR, MEM_ILL} mem_e;
    typedef struct packed {
        logic [CWRD_BITS-1:0] cwrd;
        seq_e                 seq;
        logic [ADDR_BITS-1:0] addr;
        mem_e                 mem;
    } mi_t;
    localparam mi_t NOP = '0;
    localparam logic [ADDR_BITS-1:0] ILLEGAL_DISPATCH = 6'h3F;
    localparam logic [ADDR_BITS-1:0] FETCH_ADDR       = 6'h00;
    function automatic mi_t mi(input seq_e s, input logic [ADDR_BITS-1:0] a, input mem_e m,
                               input logic [CWRD_BITS-1:0] c);
        return '{cwrd: c, seq: s, addr: a, mem: m};
    endfunction
endpackage

// File: rtl/useq_rom.sv
// useq_rom: combinational 64x40 control store and 64x6 opcode dispatch table
module useq_rom
    import useq_pkg::*;
(
    input  logic [5:0]      uaddr_i,
    input  logic [5:0]      op_i,
    output logic [MI_W-1:0] mi_o,
    output logic [5:0]      disp_o
);
    always_comb begin
        case (uaddr_i)
            FETCH_ADDR: mi_o = mi(SEQ_NEXT,     6'h00, MEM_NONE, 29'h100);
            6'h01:      mi_o = mi(SEQ_DISPATCH, 6'h00, MEM_NONE, 29'h101);
            6'h05:      mi_o = mi(SEQ_BRZ,      6'h20, MEM_NONE, 29'h105);
            6'h06:      mi_o = mi(SEQ_JUMP,     6'h00, MEM_NONE, 29'h106);
            6'h08:      mi_o = mi(SEQ_CALL,     6'h30, MEM_NONE, 29'h108);
            6'h09:      mi_o = mi(SEQ_JUMP,     6'h00, MEM_NONE, 29'h109);
            6'h0C:      mi_o = mi(SEQ_BRNZ,     6'h22, MEM_NONE, 29'h10C);
            6'h0D:      mi_o = mi(SEQ_JUMP,     6'h00, MEM_NONE, 29'h10D);
            6'h10:      mi_o = mi(SEQ_NEXT,     6'h00, MEM_RD,   29'h110);
            6'h11:      mi_o = mi(SEQ_JUMP,     6'h00, MEM_WR,   29'h111);
            6'h18:      mi_o = mi(SEQ_HALT,     6'h00, MEM_NONE, 29'h118);
            6'h1C:      mi_o = mi(SEQ_NEXT,     6'h00, MEM_ILL,  29'h11C);
            6'h20:      mi_o = mi(SEQ_JUMP,     6'h00, MEM_NONE, 29'h120);
            6'h22:      mi_o = mi(SEQ_JUMP,     6'h00, MEM_NONE, 29'h122);
            6'h30:      mi_o = mi(SEQ_RET,      6'h00, MEM_NONE, 29'h130);
            6'h31:      mi_o = mi(SEQ_RET,      6'h00, MEM_NONE, 29'h131);
            6'h3E:      mi_o = mi(SEQ_NEXT,     6'h00, MEM_NONE, 29'h13E);
            6'h3F:      mi_o = mi(SEQ_NEXT,     6'h00, MEM_NONE, 29'h13F);
            default:    mi_o = NOP;
        endcase
    end
    always_comb begin
        case (op_i)
            6'h00:   disp_o = FETCH_ADDR;
            6'h01:   disp_o = 6'h10;
            6'h02:   disp_o = 6'h05;
            6'h03:   disp_o = 6'h3E;
            6'h04:   disp_o = 6'h08;
            6'h05:   disp_o = 6'h18;
            6'h06:   disp_o = 6'h1C;
            6'h07:   disp_o = 6'h31;
            6'h08:   disp_o = 6'h0C;
            default: disp_o = ILLEGAL_DISPATCH;
        endcase
    end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control sequencer with opcode dispatch, cc branches and memory stalls
// `MICROSEQ_SUBROUTINE_EN adds a single-entry return register for CALL/RET; otherwise they halt as illegal.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int UADDR_W = 6,
    parameter int CWRD_W  = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         ire_op,
    input  logic [3:0]         cc,
    input  logic               mem_rdy,
    output logic [CWRD_W-1:0]  cwrd,
    output logic               mem_req,
    output logic               mem_we,
    output logic [UADDR_W-1:0] upc,
    output logic               halt,
    output logic               illegal
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} state_e;
    state_e             state_q, state_d;
    mi_t                mir_q, mir_d;
    logic [UADDR_W-1:0] upc_q, upc_d, upc_inc, nxt;
    logic               ill_q, ill_d, bad, stop, stall, mem_op, unused_cc;
    logic [MI_W-1:0]    rom_mi;
    logic [5:0]         disp;
`ifdef MICROSEQ_SUBROUTINE_EN
    logic [UADDR_W-1:0] ret_q, ret_d;
`endif
    useq_rom u_rom (
        .uaddr_i(nxt),
        .op_i   (ire_op),
        .mi_o   (rom_mi),
        .disp_o (disp)
    );
    assign upc_inc   = upc_q + UADDR_W'(1);
    assign mem_op    = mir_q.mem == MEM_RD || mir_q.mem == MEM_WR;
    assign stall     = mem_op && !mem_rdy;
    assign halt      = state_q == S_HALTED;
    assign illegal   = ill_q;
    assign mem_req   = mem_op && !halt;
    assign mem_we    = mem_req && mir_q.mem == MEM_WR;
    assign upc       = upc_q;
    assign cwrd      = mir_q[CWRD_LSB +: CWRD_W];
    assign unused_cc = ^cc[3:1];
    always_comb begin
        nxt  = upc_inc;
        stop = 1'b0;
        bad  = mir_q.mem == MEM_ILL;
        case (mir_q.seq)
            SEQ_JUMP:     nxt = mir_q.addr;
            SEQ_DISPATCH: begin
                nxt = disp;
                bad = bad || disp == ILLEGAL_DISPATCH;
            end
            SEQ_BRZ:      nxt = cc[0] ? mir_q.addr : upc_inc;
            SEQ_BRNZ:     nxt = cc[0] ? upc_inc : mir_q.addr;
`ifdef MICROSEQ_SUBROUTINE_EN
            SEQ_CALL:     nxt = mir_q.addr;
            SEQ_RET:      nxt = ret_q;
`else
            SEQ_CALL, SEQ_RET: bad = 1'b1;
`endif
            SEQ_HALT:     stop = 1'b1;
            default:      nxt = upc_inc;
        endcase
    end
    always_comb begin
        state_d = state_q;
        mir_d   = mir_q;
        upc_d   = upc_q;
        ill_d   = ill_q;
`ifdef MICROSEQ_SUBROUTINE_EN
        ret_d   = ret_q;
`endif
        if (state_q != S_HALTED) begin
            if (stall) begin
                state_d = S_WAIT;
            end else if (bad || stop) begin
                state_d = S_HALTED;
                mir_d   = NOP;
                ill_d   = bad;
            end else begin
                state_d = S_RUN;
                upc_d   = nxt;
                mir_d   = rom_mi;
`ifdef MICROSEQ_SUBROUTINE_EN
                ret_d   = (mir_q.seq == SEQ_CALL) ? upc_inc : ret_q;
`endif
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            mir_q   <= NOP;
            upc_q   <= FETCH_ADDR;
            ill_q   <= 1'b0;
`ifdef MICROSEQ_SUBROUTINE_EN
            ret_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mir_q   <= mir_d;
            upc_q   <= upc_d;
            ill_q   <= ill_d;
`ifdef MICROSEQ_SUBROUTINE_EN
            ret_q   <= ret_d;
`endif
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed self-checking bench for micro_sequencer
module tb_micro_sequencer;
    logic        clk = 1'b0, rst = 1'b1, mem_rdy = 1'b0;
    logic [5:0]  ire_op = '0;
    logic [3:0]  cc = '0;
    logic [28:0] cwrd;
    logic        mem_req, mem_we, halt, illegal;
    logic [5:0]  upc;
    logic [38:0] obs, e;
    int          checks = 0, failures = 0;
    assign obs = {upc, cwrd, mem_req, mem_we, halt, illegal};
    micro_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .ire_op (ire_op),
        .cc     (cc),
        .mem_rdy(mem_rdy),
        .cwrd   (cwrd),
        .mem_req(mem_req),
        .mem_we (mem_we),
        .upc    (upc),
        .halt   (halt),
        .illegal(illegal)
    );
    always #5 clk = ~clk;
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic go(input logic [5:0] op);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(2);
        ire_op = op;
        step();
        ire_op = '0;
    endtask
    task automatic test_reset;
        rst = 1'b1; mem_rdy = 1'b1; ire_op = '0; cc = '0;
        step(2);
        e = {6'h00, 29'h0, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL reset got=%h exp=%h", obs, e); end
        rst = 1'b0; mem_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            e = (i % 2 == 0) ? {6'h00, 29'h100, 4'b0000} : {6'h01, 29'h101, 4'b0000}; checks++;
            if (obs !== e) begin failures++; $display("FAIL fetch_loop%0d got=%h exp=%h", i, obs, e); end
        end
    endtask
    task automatic test_mem_read;
        mem_rdy = 1'b0;
        go(6'h01);
        for (int i = 0; i < 4; i++) begin
            e = {6'h10, 29'h110, 4'b1000}; checks++;
            if (obs !== e) begin failures++; $display("FAIL mem_wait%0d got=%h exp=%h", i, obs, e); end
            if (i == 3) mem_rdy = 1'b1;
            step();
        end
        e = {6'h11, 29'h111, 4'b1100}; checks++;
        if (obs !== e) begin failures++; $display("FAIL mem_write got=%h exp=%h", obs, e); end
        step();
        e = {6'h00, 29'h100, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL write_zero_wait got=%h exp=%h", obs, e); end
        mem_rdy = 1'b0;
    endtask
    task automatic test_reset_mid_wait;
        mem_rdy = 1'b0;
        go(6'h01);
        step();
        e = {6'h10, 29'h110, 4'b1000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL wait_held got=%h exp=%h", obs, e); end
        rst = 1'b1; mem_rdy = 1'b1;
        step();
        e = {6'h00, 29'h0, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL rst_in_wait got=%h exp=%h", obs, e); end
        rst = 1'b0; mem_rdy = 1'b0;
    endtask
    task automatic test_dispatch_illegal;
        go(6'h3F);
        e = {6'h01, 29'h0, 4'b0011}; checks++;
        if (obs !== e) begin failures++; $display("FAIL disp_illegal got=%h exp=%h", obs, e); end
        mem_rdy = 1'b1; ire_op = 6'h01;
        step(3);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL disp_sticky got=%h exp=%h", obs, e); end
        mem_rdy = 1'b0; ire_op = '0;
    endtask
    task automatic test_branch;
        go(6'h02);
        e = {6'h05, 29'h105, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL brz_entry got=%h exp=%h", obs, e); end
        cc = 4'b0001;
        step();
        e = {6'h20, 29'h120, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL brz_taken got=%h exp=%h", obs, e); end
        go(6'h02);
        cc = 4'b1110;
        step();
        e = {6'h06, 29'h106, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL brz_not got=%h exp=%h", obs, e); end
        go(6'h08);
        cc = 4'b0000;
        step();
        e = {6'h22, 29'h122, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL brnz_taken got=%h exp=%h", obs, e); end
        go(6'h08);
        cc = 4'b0001;
        step();
        e = {6'h0D, 29'h10D, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL brnz_not got=%h exp=%h", obs, e); end
        cc = '0;
    endtask
    task automatic test_wrap;
        go(6'h03);
        step();
        e = {6'h3F, 29'h13F, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL upc_63 got=%h exp=%h", obs, e); end
        step();
        e = {6'h00, 29'h100, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL upc_wrap got=%h exp=%h", obs, e); end
    endtask
    task automatic test_halt;
        go(6'h05);
        step();
        e = {6'h18, 29'h0, 4'b0010}; checks++;
        if (obs !== e) begin failures++; $display("FAIL halt got=%h exp=%h", obs, e); end
        mem_rdy = 1'b1; ire_op = 6'h01; cc = 4'b0001;
        step(3);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL halt_sticky got=%h exp=%h", obs, e); end
        rst = 1'b1;
        step();
        e = {6'h00, 29'h0, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL halt_rst got=%h exp=%h", obs, e); end
        rst = 1'b0; mem_rdy = 1'b0; ire_op = '0; cc = '0;
    endtask
    task automatic test_mem_illegal;
        go(6'h06);
        e = {6'h1C, 29'h11C, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL mem_ill_entry got=%h exp=%h", obs, e); end
        step();
        e = {6'h1C, 29'h0, 4'b0011}; checks++;
        if (obs !== e) begin failures++; $display("FAIL mem_ill_halt got=%h exp=%h", obs, e); end
    endtask
    task automatic test_subroutine;
        go(6'h04);
        e = {6'h08, 29'h108, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL call_entry got=%h exp=%h", obs, e); end
        step();
`ifdef MICROSEQ_SUBROUTINE_EN
        e = {6'h30, 29'h130, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL call got=%h exp=%h", obs, e); end
        step();
        e = {6'h09, 29'h109, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL ret got=%h exp=%h", obs, e); end
        go(6'h07);
        step();
        e = {6'h00, 29'h100, 4'b0000}; checks++;
        if (obs !== e) begin failures++; $display("FAIL ret_no_call got=%h exp=%h", obs, e); end
`else
        e = {6'h08, 29'h0, 4'b0011}; checks++;
        if (obs !== e) begin failures++; $display("FAIL call_illegal got=%h exp=%h", obs, e); end
        go(6'h07);
        step();
        e = {6'h31, 29'h0, 4'b0011}; checks++;
        if (obs !== e) begin failures++; $display("FAIL ret_illegal got=%h exp=%h", obs, e); end
`endif
    endtask
    initial begin
        test_reset();
        test_mem_read();
        test_reset_mid_wait();
        test_dispatch_illegal();
        test_branch();
        test_wrap();
        test_halt();
        test_mem_illegal();
        test_subroutine();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
